// File: rtl/apb3_slave_mem.sv
// APB3 slave with a small word-addressed register memory.
// Inserts a fixed number of wait states per access, flags misaligned or
// out-of-range addresses with PSLVERR, and drives all outputs from flops.
module apb3_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(DEPTH);
  localparam logic [2:0]          WS_L    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  enter_done_s;
  logic                  commit_s;

  // Misaligned byte address or word index beyond the memory.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH_L);
  endfunction

  // Word index of a byte address; only meaningful when addr_err() is false.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Next-state logic: setup detection, wait countdown, abort, completion.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    prdata_d     = '0;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    enter_done_s = 1'b0;
    commit_s     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // The completing access cycle commits a clean write on its closing edge.
        if ((state_q == S_DONE) && PSEL && PENABLE && write_q && !pslverr_q) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = WS_L;
          if (WS_L == 3'd0) begin
            state_d      = S_DONE;
            enter_done_s = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          // A stray PENABLE without a setup cycle lands here and is ignored.
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (PENABLE) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d      = S_DONE;
            enter_done_s = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    // addr_d/write_d hold the transfer's address and direction, even on a zero-wait setup.
    if (enter_done_s) begin
      pready_d = 1'b1;
      if (addr_err(addr_d)) begin
        pslverr_d = 1'b1;
      end else if (!write_d) begin
        prdata_d = mem_q[word_idx(addr_d)];
      end else begin
        prdata_d = '0;
      end
    end else begin
      pready_d = 1'b0;
    end
  end

  // State, latched request, registered outputs and memory; reset wins over everything.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (commit_s) begin
        mem_q[word_idx(addr_q)] <= wdata_q;
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb3_slave_mem.sv
// Directed bench for apb3_slave_mem: three instances with 0, 2 and 3 wait
// states share one APB bus, each with its own PSEL.
module tb_apb3_slave_mem;

  logic        clk;
  logic        preset;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_w [3];
  logic        pready_w [3];
  logic        pslverr_w [3];

  int checks;
  int failures;

  apb3_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_w[0]), .PREADY(pready_w[0]),
    .PSLVERR(pslverr_w[0]));

  apb3_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) u_ws2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_w[1]), .PREADY(pready_w[1]),
    .PSLVERR(pslverr_w[1]));

  apb3_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_w[2]), .PREADY(pready_w[2]),
    .PSLVERR(pslverr_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    penable = 1'b0;
  endtask

  // One full transfer on instance k, starting with the setup cycle right now
  // (just after a rising edge). Returns read data, error flag and cycle count.
  task automatic xfer(input int k, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic scramble,
                      output logic [31:0] rd, output logic err, output int cyc);
    logic done;
    done    = 1'b0;
    rd      = 32'h0;
    err     = 1'b0;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    cyc     = 1;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc     = 2;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (pready_w[k]) begin
        done = 1'b1;
        rd   = prdata_w[k];
        err  = pslverr_w[k];
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (scramble) begin
          paddr  = 8'h3C;
          pwdata = 32'hBAD0_BAD0;
        end
      end
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cyc;
    logic [31:0] pat [4];
    checks   = 0;
    failures = 0;
    preset   = 1'b1;
    pwrite   = 1'b0;
    paddr    = 8'h00;
    pwdata   = 32'h0;
    bus_idle();
    pat[0] = 32'hA0A0_0001; pat[1] = 32'h5A5A_1234;
    pat[2] = 32'hFFFF_0000; pat[3] = 32'h0000_FFFF;

    // Reset state of every instance
    repeat (2) @(posedge clk);
    #1 preset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_pready", {31'd0, pready_w[k]}, 32'd0);
      chk("rst_pslverr", {31'd0, pslverr_w[k]}, 32'd0);
      chk("rst_prdata", prdata_w[k], 32'd0);
    end
    @(posedge clk); #1;

    // Zero wait states: write then read back
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 1'b0, rd, err, cyc);
    chk("ws0_wr_cyc", cyc, 32'd2);
    chk("ws0_wr_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, 8'h04, 32'h0, 1'b0, rd, err, cyc);
    chk("ws0_rd_cyc", cyc, 32'd2);
    chk("ws0_rd_data", rd, 32'hDEAD_BEEF);
    chk("ws0_rd_err", {31'd0, err}, 32'd0);
    bus_idle();
    @(negedge clk);
    chk("prdata_idle_zero", prdata_w[0], 32'd0);
    @(posedge clk); #1;

    // Three wait states: read of an unwritten word
    xfer(2, 1'b0, 8'h10, 32'h0, 1'b0, rd, err, cyc);
    chk("ws3_rd_cyc", cyc, 32'd5);
    chk("ws3_rd_data", rd, 32'd0);
    chk("ws3_rd_err", {31'd0, err}, 32'd0);
    bus_idle();

    // Error responses: misaligned and out of range; memory untouched
    xfer(0, 1'b1, 8'h06, 32'h1111_1111, 1'b0, rd, err, cyc);
    chk("err_misal", {31'd0, err}, 32'd1);
    chk("err_misal_cyc", cyc, 32'd2);
    xfer(0, 1'b1, 8'h80, 32'h2222_2222, 1'b0, rd, err, cyc);
    chk("err_range", {31'd0, err}, 32'd1);
    xfer(0, 1'b0, 8'h80, 32'h0, 1'b0, rd, err, cyc);
    chk("err_rd_flag", {31'd0, err}, 32'd1);
    chk("err_rd_data", rd, 32'd0);
    xfer(0, 1'b0, 8'h04, 32'h0, 1'b0, rd, err, cyc);
    chk("err_readback", rd, 32'hDEAD_BEEF);
    bus_idle();

    // Stray access phase without setup is ignored
    psel[1] = 1'b1;
    penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_pready", {31'd0, pready_w[1]}, 32'd0);
    end
    @(posedge clk); #1;
    bus_idle();

    // Abort: PSEL dropped after one wait cycle
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h1234_5678;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("abort_pready_a", {31'd0, pready_w[1]}, 32'd0);
    @(posedge clk); #1 bus_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_pready_b", {31'd0, pready_w[1]}, 32'd0);
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h08, 32'h0, 1'b0, rd, err, cyc);
    chk("abort_readback", rd, 32'd0);
    chk("abort_rd_cyc", cyc, 32'd4);
    bus_idle();

    // Address/data changes during WAIT are ignored
    xfer(1, 1'b1, 8'h14, 32'h1111_2222, 1'b1, rd, err, cyc);
    chk("scr_wr_cyc", cyc, 32'd4);
    xfer(1, 1'b0, 8'h14, 32'h0, 1'b0, rd, err, cyc);
    chk("scr_readback", rd, 32'h1111_2222);
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, rd, err, cyc);
    chk("scr_other_word", rd, 32'd0);
    bus_idle();

    // Reset during WAIT of a write; then first setup right after reset
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hAAAA_5555;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 preset = 1'b1;
    @(negedge clk);
    chk("midrst_pready", {31'd0, pready_w[1]}, 32'd0);
    chk("midrst_pslverr", {31'd0, pslverr_w[1]}, 32'd0);
    chk("midrst_prdata", prdata_w[1], 32'd0);
    @(posedge clk); #1;
    preset = 1'b0;
    bus_idle();
    xfer(1, 1'b0, 8'h0C, 32'h0, 1'b0, rd, err, cyc);
    chk("midrst_rd_cyc", cyc, 32'd4);
    chk("midrst_readback", rd, 32'd0);
    xfer(1, 1'b0, 8'h14, 32'h0, 1'b0, rd, err, cyc);
    chk("midrst_cleared", rd, 32'd0);

    // Back-to-back: 4 writes then 4 reads with no idle cycles
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 8'(i * 4), pat[i], 1'b0, rd, err, cyc);
      chk("b2b_wr_cyc", cyc, 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b0, 8'(i * 4), 32'h0, 1'b0, rd, err, cyc);
      chk("b2b_rd_cyc", cyc, 32'd4);
      chk("b2b_rd_data", rd, pat[i]);
    end
    bus_idle();
    @(negedge clk);
    chk("b2b_idle_pready", {31'd0, pready_w[1]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
